// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM with retired-instruction counter
// Optional feature macro: CTRL_BNE_EN (adds bne as a branch that is taken when zero is clear)
module mips_multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_en,
   output logic             ir_write,
   output logic             iord,
   output logic             mem_write,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             imm_zext,
   output logic [1:0]       pc_src,
   output logic [3:0]       alu_oper,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired,
   output logic             retire
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IMMEX  = 4'd9,
      S_IMMWB  = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [3:0] ALU_NOT = 4'b0000;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_ADD = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1010;
   localparam logic [3:0] ALU_SRL = 4'b1011;
   localparam logic [3:0] ALU_LUI = 4'b1100;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LUI   = 6'b001111;

   state_t           state_q, state_n, cur;
   logic [CNT_W-1:0] retired_q;
   logic             is_bne;
   logic [3:0]       rt_oper;
   logic             rt_known;
   logic [3:0]       imm_oper;

`ifdef CTRL_BNE_EN
   localparam logic [5:0] OP_BNE = 6'b000101;
   assign is_bne = (opcode == OP_BNE);
`else
   assign is_bne = 1'b0;
`endif

   // Outputs decode from FETCH while reset is high so an aborted instruction issues no writes.
   assign cur     = reset ? S_FETCH : state_q;
   assign state   = state_q;
   assign retired = retired_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q <= state_n;
         if (retire)
            retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      rt_oper  = ALU_NOT;
      rt_known = 1'b1;
      case (funct)
         6'b100000: rt_oper = ALU_ADD;
         6'b100010: rt_oper = ALU_SUB;
         6'b100100: rt_oper = ALU_AND;
         6'b100101: rt_oper = ALU_OR;
         6'b100110: rt_oper = ALU_XOR;
         6'b101010: rt_oper = ALU_SLT;
         6'b000000: rt_oper = ALU_SLL;
         6'b000010: rt_oper = ALU_SRL;
         default:   rt_known = 1'b0;
      endcase
   end

   always_comb begin
      imm_oper = ALU_NOT;
      case (opcode)
         OP_ADDI: imm_oper = ALU_ADD;
         OP_ANDI: imm_oper = ALU_AND;
         OP_ORI:  imm_oper = ALU_OR;
         OP_XORI: imm_oper = ALU_XOR;
         OP_SLTI: imm_oper = ALU_SLT;
         OP_LUI:  imm_oper = ALU_LUI;
         default: imm_oper = ALU_NOT;
      endcase
   end

   always_comb begin
      state_n    = S_FETCH;
      pc_en      = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      imm_zext   = 1'b0;
      pc_src     = 2'b00;
      alu_oper   = ALU_NOT;
      retire     = 1'b0;
      case (cur)
         S_FETCH: begin
            ir_write  = 1'b1;
            pc_en     = 1'b1;
            alu_src_b = 2'b01;
            alu_oper  = ALU_ADD;
            state_n   = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            alu_oper  = ALU_ADD;
            case (opcode)
               OP_RTYPE:      state_n = S_RTEX;
               OP_LW, OP_SW:  state_n = S_MEMADR;
               OP_BEQ:        state_n = S_BRANCH;
               OP_J:          state_n = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI,
               OP_XORI, OP_SLTI, OP_LUI: state_n = S_IMMEX;
               default:       state_n = is_bne ? S_BRANCH : S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_oper  = ALU_ADD;
            state_n   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            state_n = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            retire    = 1'b1;
         end
         S_RTEX: begin
            alu_src_a = 1'b1;
            alu_oper  = rt_oper;
            state_n   = rt_known ? S_ALUWB : S_FETCH;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_oper  = ALU_SUB;
            pc_src    = 2'b01;
            pc_en     = zero ^ is_bne;
            retire    = 1'b1;
         end
         S_IMMEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_oper  = imm_oper;
            imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
            state_n   = S_IMMWB;
         end
         S_IMMWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
         end
         S_JUMP: begin
            pc_src = 2'b10;
            pc_en  = 1'b1;
            retire = 1'b1;
         end
         default: state_n = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized bench for mips_multicycle_ctrl against an instruction-level model
module tb_mips_multicycle_ctrl;

   localparam int CNT_W = 32;
`ifdef CTRL_BNE_EN
   localparam bit BNE_EN = 1'b1;
`else
   localparam bit BNE_EN = 1'b0;
`endif

   typedef struct packed {
      logic       pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
      logic [1:0] alu_src_b;
      logic       imm_zext;
      logic [1:0] pc_src;
      logic [3:0] alu_oper;
      logic       retire;
   } outs_t;

   logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
   logic [5:0] opcode = '0, funct = '0;
   logic pc_en, ir_write, iord, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, imm_zext, retire;
   logic [1:0] alu_src_b, pc_src;
   logic [3:0] alu_oper, state;
   logic [CNT_W-1:0] retired;

   int checks = 0, errors = 0;
   int unsigned ret_cnt = 0;
   int    tr_state [8];
   outs_t tr_outs  [8];

   logic [5:0] op_pool [13] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000,
                                6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001111, 6'b000101, 6'b111111};
   logic [5:0] fn_pool [9]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                6'b101010, 6'b000000, 6'b000010, 6'b111111};

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_en(pc_en), .ir_write(ir_write), .iord(iord), .mem_write(mem_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext), .pc_src(pc_src),
      .alu_oper(alu_oper), .state(state), .retired(retired), .retire(retire)
   );

   function automatic bit is_imm(input logic [5:0] op);
      return op inside {6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001111};
   endfunction

   function automatic bit is_br(input logic [5:0] op);
      return (op == 6'b000100) || (BNE_EN && op == 6'b000101);
   endfunction

   function automatic bit fn_known(input logic [5:0] fn);
      return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010, 6'b000000, 6'b000010};
   endfunction

   // Cycles from FETCH to the next FETCH for one instruction.
   function automatic int latency(input logic [5:0] op, input logic [5:0] fn);
      if (op == 6'b000000)      return fn_known(fn) ? 4 : 3;
      if (op == 6'b100011)      return 5;
      if (op == 6'b101011)      return 4;
      if (is_imm(op))           return 4;
      if (is_br(op) || op == 6'b000010) return 3;
      return 2;
   endfunction

   function automatic int state_at(input logic [5:0] op, input logic [5:0] fn, input int k);
      if (k < 2) return k;
      if (op == 6'b000000) return (k == 2) ? 6 : 7;
      if (op == 6'b100011) return k;
      if (op == 6'b101011) return (k == 2) ? 2 : 5;
      if (is_imm(op))      return (k == 2) ? 9 : 10;
      if (is_br(op))       return 8;
      return 11;
   endfunction

   function automatic logic [3:0] rt_op(input logic [5:0] fn);
      case (fn)
         6'b100000: return 4'b0101;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0001;
         6'b100101: return 4'b0011;
         6'b100110: return 4'b0010;
         6'b101010: return 4'b1000;
         6'b000010: return 4'b1011;
         6'b000000: return 4'b1010;
         default:   return 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] im_op(input logic [5:0] op);
      case (op)
         6'b001000: return 4'b0101;
         6'b001100: return 4'b0001;
         6'b001101: return 4'b0011;
         6'b001110: return 4'b0010;
         6'b001010: return 4'b1000;
         default:   return 4'b1100;
      endcase
   endfunction

   function automatic outs_t exp_out(input int st, input logic [5:0] op, input logic [5:0] fn, input logic z);
      outs_t o = '0;
      case (st)
         0:  begin o.pc_en = 1; o.ir_write = 1; o.alu_src_b = 2'b01; o.alu_oper = 4'b0101; end
         1:  begin o.alu_src_b = 2'b11; o.alu_oper = 4'b0101; end
         2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_oper = 4'b0101; end
         3:  o.iord = 1;
         4:  begin o.reg_write = 1; o.mem_to_reg = 1; o.retire = 1; end
         5:  begin o.iord = 1; o.mem_write = 1; o.retire = 1; end
         6:  begin o.alu_src_a = 1; o.alu_oper = rt_op(fn); end
         7:  begin o.reg_write = 1; o.reg_dst = 1; o.retire = 1; end
         8:  begin o.alu_src_a = 1; o.alu_oper = 4'b0110; o.pc_src = 2'b01;
                   o.pc_en = (op == 6'b000101) ? ~z : z; o.retire = 1; end
         9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_oper = im_op(op);
                   o.imm_zext = op inside {6'b001100, 6'b001101, 6'b001110}; end
         10: begin o.reg_write = 1; o.retire = 1; end
         default: begin o.pc_src = 2'b10; o.pc_en = 1; o.retire = 1; end
      endcase
      return o;
   endfunction

   function automatic outs_t dut_out();
      outs_t o;
      o.pc_en = pc_en; o.ir_write = ir_write; o.iord = iord; o.mem_write = mem_write;
      o.reg_write = reg_write; o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
      o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b; o.imm_zext = imm_zext;
      o.pc_src = pc_src; o.alu_oper = alu_oper; o.retire = retire;
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Entered just after a rising edge; runs one whole instruction and leaves just after the next FETCH edge.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
      int n = latency(op, fn);
      outs_t e;
      for (int k = 0; k < n; k++) begin
         opcode = op;
         funct  = fn;
         zero   = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         @(negedge clk);
         e = exp_out(state_at(op, fn, k), op, fn, zero);
         chk("state", 32'(state), 32'(state_at(op, fn, k)));
         chk("outputs", 32'(dut_out()), 32'(e));
         chk("retired", retired, ret_cnt);
         tr_state[k] = int'(state);
         tr_outs[k]  = dut_out();
         if (e.retire) ret_cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int r0;
      outs_t f0;
      f0 = exp_out(0, 6'd0, 6'd0, 1'b0);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("reset_outputs", 32'(dut_out()), 32'(f0));
         @(posedge clk);
      end
      #1;
      reset   = 1'b0;
      ret_cnt = 0;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_retired", retired, 32'd0);

      run_instr(6'b000000, 6'b100010, 2);
      chk("sub_s1", tr_state[1], 1);
      chk("sub_s2", tr_state[2], 6);
      chk("sub_s3", tr_state[3], 7);
      chk("sub_oper", 32'(tr_outs[2].alu_oper), 32'b0110);
      chk("sub_wb", {tr_outs[3].reg_write, tr_outs[3].reg_dst}, 2'b11);
      chk("sub_retired", retired, 1);

      run_instr(6'b100011, 6'b000000, 2);
      chk("lw_s4", tr_state[4], 4);
      chk("lw_iord", 32'(tr_outs[3].iord), 1);
      chk("lw_wb", {tr_outs[4].mem_to_reg, tr_outs[4].reg_write}, 2'b11);
      chk("lw_retired", retired, 2);

      run_instr(6'b101011, 6'b000000, 2);
      chk("sw_s3", tr_state[3], 5);
      chk("sw_memw", {tr_outs[0].mem_write, tr_outs[1].mem_write, tr_outs[2].mem_write, tr_outs[3].mem_write}, 4'b0001);
      chk("sw_retired", retired, 3);

      run_instr(6'b000100, 6'b000000, 1);
      chk("beq_t", {tr_outs[2].pc_en, tr_outs[2].pc_src}, 3'b101);
      run_instr(6'b000100, 6'b000000, 0);
      chk("beq_nt", 32'(tr_outs[2].pc_en), 0);
      chk("beq_retired", retired, 5);

      run_instr(6'b001101, 6'b000000, 2);
      chk("ori_ex", {tr_outs[2].alu_oper, tr_outs[2].imm_zext}, 5'b0011_1);
      chk("ori_wb", {tr_outs[3].reg_write, tr_outs[3].reg_dst}, 2'b10);
      run_instr(6'b001111, 6'b000000, 2);
      chk("lui_ex", {tr_outs[2].alu_oper, tr_outs[2].imm_zext}, 5'b1100_0);
      chk("imm_retired", retired, 7);

      run_instr(6'b111111, 6'b000000, 2);
      chk("illegal_retired", retired, 7);
      run_instr(6'b000000, 6'b111111, 2);
      chk("badfn_nowr", {tr_outs[0].reg_write, tr_outs[1].reg_write, tr_outs[2].reg_write}, 3'b000);
      chk("badfn_retired", retired, 7);

      run_instr(6'b000101, 6'b000000, 0);
      if (BNE_EN) begin
         chk("bne_taken", 32'(tr_outs[2].pc_en), 1);
         chk("bne_retired", retired, 8);
      end else begin
         chk("bne_illegal", retired, 7);
      end

      // Abort a load in MEMRD.
      for (int k = 0; k < 4; k++) begin
         opcode = 6'b100011;
         zero   = 1'b0;
         reset  = (k == 3);
         @(negedge clk);
         if (k == 3) chk("abort_nowr", {reg_write, mem_write}, 2'b00);
         else chk("abort_pre_state", 32'(state), 32'(k));
         @(posedge clk);
         #1;
      end
      reset   = 1'b0;
      ret_cnt = 0;
      chk("abort_state", 32'(state), 0);
      chk("abort_retired", retired, 0);
      run_instr(6'b000010, 6'b000000, 2);
      chk("jump_after_abort", retired, 1);

      for (int i = 0; i < 400; i++) begin
         logic [5:0] op, fn;
         r0 = $urandom_range(0, 13);
         op = (r0 == 13) ? 6'($urandom) : op_pool[r0];
         r0 = $urandom_range(0, 9);
         fn = (r0 == 9) ? 6'($urandom) : fn_pool[r0];
         run_instr(op, fn, 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
